result_collector: RTL and testbench

Downstream stage for the divider→multiplier chain: captures each `product` word qualified by the chain's one-cycle `done_sig` pulse into a small circular buffer. Presents the words on a valid/ready output stream. The chain has no back-pressure input, so the collector absorbs bursts, counts dropped results on overflow and keeps a sticky overflow flag. An optional running sum of collected results is compiled in by macro.

---
 rtl/result_collector.sv | 152 +++++++++++++++
 tb/tb_result_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector: captures done_sig-qualified product words into a circular
// buffer and presents them on a valid/ready stream through a registered output
// stage. Overflowing results are dropped and counted.
// Optional feature macro: RESULT_COLLECTOR_SUM_EN adds a saturating running sum
// of accepted results on port result_sum.
module result_collector #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     done_sig,
   input  logic [DW-1:0]            product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
`ifdef RESULT_COLLECTOR_SUM_EN
   ,
   output logic [23:0]              result_sum
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [0:0] {IDLE, VALID} state_t;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_w;
   logic          empty_w, full_w;
   logic          pop_w, push_w, drop_w;

   state_t        state_q;
   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic          overflow_q;
   logic [7:0]    drop_cnt_q;

   // Occupancy and the per-edge write/pop/drop decisions
   always_comb begin
      level_w = wr_ptr_q - rd_ptr_q;
      empty_w = (level_w == '0);
      full_w  = (level_w == (AW+1)'(DEPTH));
      pop_w   = !empty_w && ((state_q == IDLE) || out_ready);
      push_w  = done_sig && (!full_w || pop_w);
      drop_w  = done_sig && full_w && !pop_w;
   end

   // Buffer storage; contents are not reset, only pointers are
   always_ff @(posedge clk) begin
      if (!rst && !clear && push_w)
         mem_q[wr_ptr_q[AW-1:0]] <= product;
   end

   // Write and read pointers, one extra MSB separates full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Output FSM with registered valid/data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (clear) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty_w) begin
                  out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                  out_valid_q <= 1'b1;
                  state_q     <= VALID;
               end
            end
            VALID: begin
               if (out_ready) begin
                  if (!empty_w) begin
                     out_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                  end else begin
                     out_valid_q <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (clear) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop_w) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

`ifdef RESULT_COLLECTOR_SUM_EN
   logic [23:0] sum_q;
   logic [24:0] sum_add_w;

   // Running sum of accepted words with carry-out detection
   always_comb begin
      sum_add_w = {1'b0, sum_q} + 25'(product);
   end

   // Saturating accumulator, updated only on accepted writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else if (clear) begin
         sum_q <= '0;
      end else if (push_w) begin
         sum_q <= sum_add_w[24] ? '1 : sum_add_w[23:0];
      end
   end

   assign result_sum = sum_q;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign level     = level_w;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_result_collector;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          done_sig = 1'b0;
   logic [DW-1:0] product = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [LW-1:0] level;
   logic          overflow;
   logic [7:0]    drop_cnt;
`ifdef RESULT_COLLECTOR_SUM_EN
   logic [23:0]   result_sum;
`endif

   int vectors = 0;
   int miscompares = 0;

   result_collector #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .done_sig  (done_sig),
      .product   (product),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
`ifdef RESULT_COLLECTOR_SUM_EN
      ,
      .result_sum(result_sum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words in the buffer as a queue, output register separate
   logic [DW-1:0] mq[$];
   bit            m_ov = 0;
   logic [DW-1:0] m_od = '0;
   bit            m_ovf = 0;
   int            m_drop = 0;
   longint        m_sum = 0;

   always @(posedge clk or posedge rst) begin
      bit            hs, pop, was_full;
      logic [DW-1:0] head;
      if (rst) begin
         mq.delete(); m_ov = 0; m_od = '0; m_ovf = 0; m_drop = 0; m_sum = 0;
      end else if (clear) begin
         mq.delete(); m_ov = 0; m_ovf = 0; m_drop = 0; m_sum = 0;
      end else begin
         hs       = m_ov && out_ready;
         pop      = (!m_ov || hs) && (mq.size() > 0);
         was_full = (mq.size() == DEPTH);
         head     = '0;
         if (pop) head = mq.pop_front();
         if (done_sig) begin
            if (!was_full || pop) begin
               mq.push_back(product);
               m_sum = m_sum + longint'(product);
               if (m_sum > 64'hFFFFFF) m_sum = 64'hFFFFFF;
            end else begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end
         end
         if (pop) begin
            m_ov = 1; m_od = head;
         end else if (hs) begin
            m_ov = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_valid", out_valid, m_ov);
         if (m_ov) chk("m_data", out_data, m_od);
         chk("m_level", level, mq.size());
         chk("m_overflow", overflow, m_ovf);
         chk("m_drop_cnt", drop_cnt, m_drop);
`ifdef RESULT_COLLECTOR_SUM_EN
         chk("m_sum", result_sum, m_sum);
`endif
      end
   end

   logic [DW-1:0] got[$];

   // Apply one cycle of inputs; records the word handshaken at the coming edge
   task automatic cyc(input bit d, input logic [DW-1:0] p, input bit r, input bit c);
      done_sig  = d;
      product   = p;
      out_ready = r;
      clear     = c;
      if (out_valid && r && !c) got.push_back(out_data);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 1'b0;
      cyc(0, '0, 0, 0);

      // Single result, two-cycle latency, one-cycle valid
      cyc(1, 16'h1234, 1, 0);
      chk("single_valid_t0", out_valid, 0);
      chk("single_level_t0", level, 1);
      cyc(0, '0, 1, 0);
      chk("single_valid_t1", out_valid, 1);
      chk("single_data_t1", out_data, 16'h1234);
      chk("single_level_t1", level, 0);
      cyc(0, '0, 1, 0);
      chk("single_valid_t2", out_valid, 0);
      got.delete();

      // Fill and overflow with consumer stalled
      for (int i = 1; i <= 11; i++) cyc(1, DW'(i), 0, 0);
      cyc(0, '0, 0, 0);
      chk("fill_level", level, 8);
      chk("fill_overflow", overflow, 1);
      chk("fill_drop", drop_cnt, 2);
      got.delete();
      for (int i = 0; i < 15; i++) cyc(0, '0, 1, 0);
      chk("fill_count", got.size(), 9);
      for (int i = 0; i < 9 && i < got.size(); i++) chk("fill_order", got[i], i + 1);
      cyc(0, '0, 0, 1);
      chk("clear_overflow", overflow, 0);
      chk("clear_drop", drop_cnt, 0);
      got.delete();

      // Full buffer with a simultaneous pop accepts the incoming word
      for (int i = 1; i <= 9; i++) cyc(1, DW'(16'h20 + i), 0, 0);
      chk("full_level", level, 8);
      cyc(1, 16'h00AA, 1, 0);
      chk("fullpop_level", level, 8);
      chk("fullpop_drop", drop_cnt, 0);
      chk("fullpop_overflow", overflow, 0);
      for (int i = 0; i < 12; i++) cyc(0, '0, 1, 0);
      chk("fullpop_count", got.size(), 10);
      if (got.size() == 10) chk("fullpop_last", got[9], 16'h00AA);
      got.delete();

      // Wrap-around stream with toggling ready
      for (int i = 0; i < 20; i++) cyc(1, DW'(100 + i), (i % 3) != 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, '0, (i % 2) == 0, 0);
      chk("wrap_count", got.size(), 20);
      for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_order", got[i], 100 + i);
      chk("wrap_drop", drop_cnt, 0);
      got.delete();

      // Clear mid-stream with a simultaneous result
      for (int i = 0; i < 3; i++) cyc(1, DW'(16'h50 + i), 0, 0);
      cyc(1, 16'hDEAD, 0, 1);
      chk("clr_valid", out_valid, 0);
      chk("clr_level", level, 0);
      chk("clr_drop", drop_cnt, 0);
      for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);
      chk("clr_nothing_out", got.size(), 0);

`ifdef RESULT_COLLECTOR_SUM_EN
      for (int i = 0; i < 300; i++) cyc(1, 16'hFFFF, 1, 0);
      cyc(0, '0, 1, 0);
      chk("sum_saturate", result_sum, 24'hFFFFFF);
`endif

      // Asynchronous reset in the middle of activity
      got.delete();
      for (int i = 0; i < 4; i++) cyc(1, DW'(16'h70 + i), 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_level", level, 0);
      chk("arst_overflow", overflow, 0);
      chk("arst_drop", drop_cnt, 0);
`ifdef RESULT_COLLECTOR_SUM_EN
      chk("arst_sum", result_sum, 0);
`endif
      done_sig = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
      chk("post_rst_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
